// File: rtl/flappy_pkg.sv
// Shared screen geometry and game-state encoding for the bird stage, pipe field and renderer.
package flappy_pkg;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int BIRD_SIZE = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      OVER  = 2'd3
   } state_e;

endpackage

// File: rtl/lfsr9.sv
// 9-bit Fibonacci LFSR, x^9 + x^5 + 1, free-running every clock.
module lfsr9 (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] seed,
   output logic [8:0] q
);

   logic [8:0] q_q;
   logic [8:0] q_d;

   always_comb begin
      q_d = {q_q[7:0], q_q[8] ^ q_q[4]};
   end

   always_ff @(posedge clock) begin
      if (!reset) q_q <= seed;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_field.sv
// Two scrolling pipe obstacles with random gaps, collision detection and score keeping.
//
// state | meaning
// IDLE  | pipes parked at start positions, waiting for game_state
// RUN   | scrolling on each unpaused tick
// CHECK | one clock: recycle, score and collide using the moved pipes
// OVER  | everything frozen until game_state drops
module pipe_field
   import flappy_pkg::*;
#(
   parameter int         PIPE_W       = 52,
   parameter int         GAP_H        = 120,
   parameter int         GAP_MIN      = 60,
   parameter int         PIPE_SPACING = 320,
   parameter int         SCROLL_SPEED = 2,
   parameter logic [8:0] LFSR_SEED    = 9'h1A5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       pause,
   input  logic       game_state,
   input  logic [7:0] bird_x,
   input  logic [8:0] bird_y,
   output logic [9:0] pipe0_x,
   output logic [8:0] pipe0_gap_y,
   output logic [9:0] pipe1_x,
   output logic [8:0] pipe1_gap_y,
   output logic       collision,
   output logic       score_inc,
   output logic [9:0] current_score,
   output logic [9:0] highest_score
);

   localparam logic [9:0]  X0_RST    = 10'(SCREEN_W + PIPE_W);
   localparam logic [9:0]  X1_RST    = 10'(SCREEN_W + PIPE_W + PIPE_SPACING);
   localparam logic [8:0]  GAP_RST   = 9'(GAP_MIN + 120);
   localparam logic [9:0]  SPEED     = 10'(SCROLL_SPEED);
   localparam logic [9:0]  SPACING   = 10'(PIPE_SPACING);
   localparam logic [10:0] HSPAN     = 11'(BIRD_SIZE + PIPE_W);
   localparam logic [9:0]  BSIZE     = 10'(BIRD_SIZE);
   localparam logic [9:0]  GAPH      = 10'(GAP_H);
   localparam logic [9:0]  CEIL_Y    = 10'(SCREEN_H - BIRD_SIZE);
   localparam logic [9:0]  SCORE_MAX = 10'd999;

   state_e           state_q, state_d;
   logic [1:0][9:0]  px_q, px_d;
   logic [1:0][8:0]  gap_q, gap_d;
   logic [9:0]       cur_q, cur_d;
   logic [9:0]       hi_q, hi_d;
   logic             coll_q, coll_d;
   logic             inc_q, inc_d;

   logic [8:0]  lfsr_q;
   logic        unused_lfsr_msb;
   logic [8:0]  gap_rand;

   lfsr9 u_lfsr (
      .clock (clock),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   assign unused_lfsr_msb = lfsr_q[8];
   assign gap_rand        = 9'(GAP_MIN) + {1'b0, lfsr_q[7:0]};

   logic [10:0] bx_w;
   logic [9:0]  by_w;
   logic [1:0]  overlap, outside, passed;
   logic [1:0]  n_pass;
   logic [10:0] score_sum;
   logic [9:0]  cur_next;
   logic        hit;

   assign bx_w = {3'b000, bird_x};
   assign by_w = {1'b0, bird_y};

   // All compares are widened so bird_x+BIRD_SIZE+PIPE_W and gap_y+GAP_H never wrap.
   always_comb begin
      overlap = '0;
      outside = '0;
      passed  = '0;
      for (int i = 0; i < 2; i++) begin
         overlap[i] = (bx_w < {1'b0, px_q[i]}) && ((bx_w + HSPAN) > {1'b0, px_q[i]});
         outside[i] = (by_w < {1'b0, gap_q[i]}) || ((by_w + BSIZE) > ({1'b0, gap_q[i]} + GAPH));
         passed[i]  = (({1'b0, px_q[i]} + {1'b0, SPEED}) > bx_w) && ({1'b0, px_q[i]} <= bx_w);
      end
      n_pass    = {1'b0, passed[0]} + {1'b0, passed[1]};
      score_sum = {1'b0, cur_q} + {9'd0, n_pass};
      cur_next  = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
      hit       = (|(overlap & outside)) || (bird_y == '0) || (by_w >= CEIL_Y);
   end

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      gap_d   = gap_q;
      cur_d   = cur_q;
      hi_d    = hi_q;
      coll_d  = coll_q;
      inc_d   = 1'b0;
      case (state_q)
         IDLE: begin
            px_d   = {X1_RST, X0_RST};
            gap_d  = {GAP_RST, GAP_RST};
            coll_d = 1'b0;
            if (game_state) begin
               state_d = RUN;
               cur_d   = '0;
            end
         end
         RUN: begin
            if (!game_state) begin
               state_d = IDLE;
            end else if (tick && !pause) begin
               for (int i = 0; i < 2; i++) begin
                  px_d[i] = (px_q[i] >= SPEED) ? (px_q[i] - SPEED) : '0;
               end
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Pipe0 wins if both reach the left edge on the same check.
            if (px_q[0] <= SPEED) begin
               px_d[0]  = px_q[1] + SPACING;
               gap_d[0] = gap_rand;
            end else if (px_q[1] <= SPEED) begin
               px_d[1]  = px_q[0] + SPACING;
               gap_d[1] = gap_rand;
            end
            if (n_pass != 2'd0) begin
               inc_d = 1'b1;
               cur_d = cur_next;
               if (cur_next > hi_q) hi_d = cur_next;
            end
            if (hit) begin
               coll_d  = 1'b1;
               state_d = OVER;
            end else begin
               state_d = RUN;
            end
         end
         OVER: begin
            if (!game_state) begin
               state_d = IDLE;
               coll_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         px_q    <= {X1_RST, X0_RST};
         gap_q   <= {GAP_RST, GAP_RST};
         cur_q   <= '0;
         hi_q    <= '0;
         coll_q  <= 1'b0;
         inc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         gap_q   <= gap_d;
         cur_q   <= cur_d;
         hi_q    <= hi_d;
         coll_q  <= coll_d;
         inc_q   <= inc_d;
      end
   end

   assign pipe0_x       = px_q[0];
   assign pipe1_x       = px_q[1];
   assign pipe0_gap_y   = gap_q[0];
   assign pipe1_gap_y   = gap_q[1];
   assign collision     = coll_q;
   assign score_inc     = inc_q;
   assign current_score = cur_q;
   assign highest_score = hi_q;

endmodule

// File: tb/tb_pipe_field.sv
// Bench for pipe_field: hand-computed geometry table, directed corner sequences and a randomized run.
module tb_pipe_field;

   logic       clock = 1'b0;
   logic       reset, tick, pause, game_state;
   logic [7:0] bird_x;
   logic [8:0] bird_y;
   logic [9:0] pipe0_x, pipe1_x, current_score, highest_score;
   logic [8:0] pipe0_gap_y, pipe1_gap_y;
   logic       collision, score_inc;

   int total = 0;
   int bad   = 0;

   pipe_field dut (
      .clock         (clock),
      .reset         (reset),
      .tick          (tick),
      .pause         (pause),
      .game_state    (game_state),
      .bird_x        (bird_x),
      .bird_y        (bird_y),
      .pipe0_x       (pipe0_x),
      .pipe0_gap_y   (pipe0_gap_y),
      .pipe1_x       (pipe1_x),
      .pipe1_gap_y   (pipe1_gap_y),
      .collision     (collision),
      .score_inc     (score_inc),
      .current_score (current_score),
      .highest_score (highest_score)
   );

   always #5 clock = ~clock;

   // Reference LFSR value, kept as plain integer arithmetic.
   int m_lfsr;
   always @(posedge clock) begin
      if (!reset) m_lfsr <= 'h1A5;
      else        m_lfsr <= ((m_lfsr * 2) & 511) | (((m_lfsr >> 8) ^ (m_lfsr >> 4)) & 1);
   end

   // Game-level reference model.
   int mp[2];
   int mg[2];
   int mcur, mhi, mcoll, mrun, minc;

   typedef struct {
      int bx;
      int by;
      int ticks;
      int ep0;
      int ecoll;
      int escore;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_pipe0_x"}, int'(pipe0_x), mp[0]);
      chk({tag, "_pipe1_x"}, int'(pipe1_x), mp[1]);
      chk({tag, "_gap0"}, int'(pipe0_gap_y), mg[0]);
      chk({tag, "_gap1"}, int'(pipe1_gap_y), mg[1]);
      chk({tag, "_collision"}, int'(collision), mcoll);
      chk({tag, "_score_inc"}, int'(score_inc), minc);
      chk({tag, "_cur"}, int'(current_score), mcur);
      chk({tag, "_hi"}, int'(highest_score), mhi);
   endtask

   task automatic model_park();
      mp[0] = 692;
      mp[1] = 1012;
      mg[0] = 180;
      mg[1] = 180;
      minc  = 0;
   endtask

   task automatic model_reset();
      model_park();
      mcur  = 0;
      mhi   = 0;
      mcoll = 0;
      mrun  = 0;
   endtask

   task automatic model_tick(input bit pz, input int lf);
      int old[2];
      int passes;
      int bx, by;
      bit hit;
      minc = 0;
      if (!mrun || pz) return;
      bx     = int'(bird_x);
      by     = int'(bird_y);
      hit    = (by == 0) || (by >= 480 - 16);
      passes = 0;
      for (int i = 0; i < 2; i++) begin
         old[i] = mp[i];
         mp[i]  = (mp[i] >= 2) ? mp[i] - 2 : 0;
         if (old[i] > bx && mp[i] <= bx) passes++;
         if (bx < mp[i] && bx + 16 > mp[i] - 52 && (by < mg[i] || by + 16 > mg[i] + 120)) hit = 1'b1;
      end
      if (mp[0] <= 2) begin
         mp[0] = mp[1] + 320;
         mg[0] = 60 + (lf % 256);
      end else if (mp[1] <= 2) begin
         mp[1] = mp[0] + 320;
         mg[1] = 60 + (lf % 256);
      end
      if (passes > 0) begin
         minc = 1;
         mcur = (mcur + passes > 999) ? 999 : mcur + passes;
         if (mcur > mhi) mhi = mcur;
      end
      if (hit) begin
         mcoll = 1;
         mrun  = 0;
      end
   endtask

   task automatic do_tick(input bit pz);
      int lf;
      pause = pz;
      tick  = 1'b1;
      cyc();
      tick = 1'b0;
      lf   = m_lfsr;
      cyc();
      model_tick(pz, lf);
      check_model("tick");
      cyc();
      chk("score_inc_one_clock", int'(score_inc), 0);
      minc = 0;
   endtask

   task automatic start_game();
      tick       = 1'b0;
      pause      = 1'b0;
      game_state = 1'b0;
      cyc();
      cyc();
      game_state = 1'b1;
      cyc();
      model_park();
      mcur  = 0;
      mcoll = 0;
      mrun  = 1;
   endtask

   task automatic pick_safe_y();
      int bx, near;
      bx   = int'(bird_x);
      near = (mp[0] > bx && (mp[1] <= bx || mp[0] < mp[1])) ? 0 : 1;
      bird_y = 9'(mg[near] + $urandom_range(0, 104));
   endtask

   initial begin
      reset = 1'b0; tick = 1'b0; pause = 1'b0; game_state = 1'b0;
      bird_x = 8'd0; bird_y = 9'd0;
      model_reset();
      vecs[0] = '{100, 200, 296, 100, 0, 1};
      vecs[1] = '{100, 284, 300,  92, 0, 1};
      vecs[2] = '{100, 179, 262, 168, 0, 0};
      vecs[3] = '{100, 179, 300, 166, 1, 0};
      vecs[4] = '{100, 285, 300, 166, 1, 0};
      vecs[5] = '{100,   0,   5, 690, 1, 0};
      vecs[6] = '{100,   1,   5, 682, 0, 0};
      vecs[7] = '{100, 464,   5, 690, 1, 0};
      vecs[8] = '{200, 463, 250, 266, 1, 0};
      vecs[9] = '{  0, 180, 340,  12, 0, 0};
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      check_model("reset");

      // First tick of a new game.
      bird_x = 8'd100;
      bird_y = 9'd200;
      start_game();
      do_tick(1'b0);
      chk("first_tick_pipe0", int'(pipe0_x), 690);
      chk("first_tick_pipe1", int'(pipe1_x), 1010);

      for (int v = 0; v < 10; v++) begin
         bird_x = 8'(vecs[v].bx);
         bird_y = 9'(vecs[v].by);
         start_game();
         repeat (vecs[v].ticks) do_tick(1'b0);
         chk($sformatf("vec%0d_pipe0", v), int'(pipe0_x), vecs[v].ep0);
         chk($sformatf("vec%0d_collision", v), int'(collision), vecs[v].ecoll);
         chk($sformatf("vec%0d_score", v), int'(current_score), vecs[v].escore);
      end

      // Collision clears when game_state drops, then pipes park.
      bird_x = 8'd100;
      bird_y = 9'd0;
      start_game();
      do_tick(1'b0);
      chk("over_collision", int'(collision), 1);
      game_state = 1'b0;
      cyc();
      chk("idle_collision_clear", int'(collision), 0);
      cyc();
      chk("idle_pipe0_parked", int'(pipe0_x), 692);
      chk("idle_pipe1_parked", int'(pipe1_x), 1012);
      mcoll = 0;
      mrun  = 0;

      // Pause drops ticks; release moves again.
      bird_y = 9'd200;
      start_game();
      repeat (3) do_tick(1'b0);
      repeat (10) do_tick(1'b1);
      chk("paused_pipe0", int'(pipe0_x), 686);
      do_tick(1'b0);
      chk("released_pipe0", int'(pipe0_x), 684);

      // Long game following the gaps, covering recycles and repeated scoring.
      bird_x = 8'($urandom_range(120, 200));
      start_game();
      for (int t = 0; t < 1300; t++) begin
         pick_safe_y();
         do_tick($urandom_range(0, 9) == 0);
      end

      // Reset in the middle of a running game.
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      model_reset();
      check_model("midrun_reset");
      chk("midrun_reset_hi", int'(highest_score), 0);

      // Random games with occasional fatal bird positions.
      for (int t = 0; t < 700; t++) begin
         if (!mrun) begin
            bird_x = 8'($urandom_range(0, 255));
            start_game();
         end
         if ($urandom_range(0, 24) == 0) bird_y = 9'($urandom_range(0, 479));
         else pick_safe_y();
         do_tick($urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
